// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN datapath blocks.
// Provides default data widths, a constant-evaluable ceil(log2) and small
// helpers describing the size and latency of a KxK multiply-adder tree.
package cnn_pkg;

    localparam int CNN_PIXEL_W  = 8;
    localparam int CNN_WEIGHT_W = 8;
    localparam int CNN_ACC_W    = 32;

    // ceil(log2(v)); returns 0 for v <= 1.
    function automatic int CLOG2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Number of elements in a KxK window.
    function automatic int win_size(input int k);
        return k * k;
    endfunction

    // Number of live partial sums at reduction level l of an n-input tree.
    function automatic int tree_count(input int n, input int l);
        return (n + (32'sd1 <<< l) - 32'sd1) >>> l;
    endfunction

    // Edges from window capture to result: one product stage plus adder levels.
    function automatic int tree_latency(input int k);
        return 32'sd1 + CLOG2(k * k);
    endfunction

endpackage

// File: rtl/mult_adder_tree.sv
// One kernel's multiply + pipelined adder reduction.
// Ports:
//   clock, reset      rising-edge clock, asynchronous active-low reset
//   in_valid_i        the window on pixels_i is a real (in-image) window
//   pixels_i          N unsigned pixels, element i at [i*PIXEL_W +: PIXEL_W]
//   weights_i         N signed weights, element i at [i*WEIGHT_W +: WEIGHT_W]
//   out_valid_o       sum_o holds a fresh result
//   sum_o             signed sum, held while out_valid_o is low
// Latency is 1 + CLOG2(N) edges. With CONV2D_STREAM_RELU_EN defined the final
// sum is clamped at zero before it is registered.
module mult_adder_tree
    import cnn_pkg::*;
#(
    parameter int N        = 9,
    parameter int PIXEL_W  = CNN_PIXEL_W,
    parameter int WEIGHT_W = CNN_WEIGHT_W,
    parameter int ACC_W    = CNN_ACC_W
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    in_valid_i,
    input  logic [N*PIXEL_W-1:0]    pixels_i,
    input  logic [N*WEIGHT_W-1:0]   weights_i,
    output logic                    out_valid_o,
    output logic [ACC_W-1:0]        sum_o
);

    localparam int LEVELS = CLOG2(N);
    localparam int PROD_W = PIXEL_W + WEIGHT_W + 1;

    // lvl_*[0] are the products; lvl_*[l] the partial sums of adder level l.
    logic signed [ACC_W-1:0] lvl_d [LEVELS][N];
    logic signed [ACC_W-1:0] lvl_q [LEVELS][N];
    logic signed [ACC_W-1:0] final_s;
    logic        [ACC_W-1:0] sum_d;
    logic        [ACC_W-1:0] sum_q;
    logic        [LEVELS-1:0] vld_q;
    logic                    out_valid_q;

    // Zero-extend the pixel, signed multiply, sign-extend to the accumulator.
    function automatic logic signed [ACC_W-1:0] mul_ext(
        input logic        [PIXEL_W-1:0]  px,
        input logic signed [WEIGHT_W-1:0] w
    );
        logic signed [PIXEL_W:0]  pxs;
        logic signed [PROD_W-1:0] p;
        pxs = {1'b0, px};
        p   = pxs * w;
        return ACC_W'(p);
    endfunction

    // Keeps constant-unrolled indices in range on branches that never fire.
    function automatic int safe_idx(input int j);
        return (j < N) ? j : 0;
    endfunction

    // Products and pairwise reduction; an odd trailing element passes through.
    always_comb begin
        for (int l = 0; l < LEVELS; l++) begin
            for (int i = 0; i < N; i++) begin
                lvl_d[l][i] = '0;
            end
        end
        for (int i = 0; i < N; i++) begin
            lvl_d[0][i] = mul_ext(pixels_i[i*PIXEL_W +: PIXEL_W],
                                  weights_i[i*WEIGHT_W +: WEIGHT_W]);
        end
        for (int l = 1; l < LEVELS; l++) begin
            for (int i = 0; i < N; i++) begin
                if (2 * i + 1 < tree_count(N, l - 1)) begin
                    lvl_d[l][i] = lvl_q[l-1][safe_idx(2 * i)] + lvl_q[l-1][safe_idx(2 * i + 1)];
                end else if (2 * i < tree_count(N, l - 1)) begin
                    lvl_d[l][i] = lvl_q[l-1][safe_idx(2 * i)];
                end else begin
                    lvl_d[l][i] = '0;
                end
            end
        end
        // The last level always holds exactly two partial sums.
        final_s = lvl_q[LEVELS-1][0] + lvl_q[LEVELS-1][1];
`ifdef CONV2D_STREAM_RELU_EN
        if (final_s[ACC_W-1]) begin
            sum_d = '0;
        end else begin
            sum_d = final_s;
        end
`else
        sum_d = final_s;
`endif
    end

    // Pipeline registers; the output register only loads on a valid result.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            vld_q       <= '0;
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            for (int l = 0; l < LEVELS; l++) begin
                for (int i = 0; i < N; i++) begin
                    lvl_q[l][i] <= '0;
                end
            end
        end else begin
            vld_q       <= {vld_q[LEVELS-2:0], in_valid_i};
            out_valid_q <= vld_q[LEVELS-1];
            lvl_q       <= lvl_d;
            if (vld_q[LEVELS-1]) begin
                sum_q <= sum_d;
            end else begin
                sum_q <= sum_q;
            end
        end
    end

    assign out_valid_o = out_valid_q;
    assign sum_o       = sum_q;

endmodule

// File: rtl/conv2d_stream.sv
// Streaming KxK 2D convolution over raster-order pixels.
// Ports:
//   clock, reset   rising-edge clock, asynchronous active-low reset
//   pixel_in       unsigned pixel, accepted when pixel_valid is high
//   pixel_valid    accept strobe; low freezes window and position counters
//   sof            with pixel_valid, forces this pixel to position (0,0)
//   kernel         NUM_KERNELS*K*K signed weights, kernel n element r*K+c at
//                  [(n*K*K + r*K + c)*WEIGHT_W +: WEIGHT_W]
//   pixel_out      kernel n result at [n*ACC_W +: ACC_W]
//   out_valid      pixel_out carries a new window result
// Optional macro CONV2D_STREAM_RELU_EN clamps negative results to zero.
module conv2d_stream
    import cnn_pkg::*;
#(
    parameter int PIXEL_W     = CNN_PIXEL_W,
    parameter int WEIGHT_W    = CNN_WEIGHT_W,
    parameter int ACC_W       = CNN_ACC_W,
    parameter int K           = 3,
    parameter int IMG_W       = 8,
    parameter int IMG_H       = 8,
    parameter int NUM_KERNELS = 2
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic [PIXEL_W-1:0]                    pixel_in,
    input  logic                                  pixel_valid,
    input  logic                                  sof,
    input  logic [NUM_KERNELS*K*K*WEIGHT_W-1:0]   kernel,
    output logic [NUM_KERNELS*ACC_W-1:0]          pixel_out,
    output logic                                  out_valid
);

    localparam int WIN_N = win_size(K);
    localparam int CW    = CLOG2(IMG_W);
    localparam int RW    = CLOG2(IMG_H);

    logic [CW-1:0]      col_q, col_d, cur_col_s;
    logic [RW-1:0]      row_q, row_d, cur_row_s;
    logic               win_ok_s;
    logic               win_valid_q;
    logic [PIXEL_W-1:0] lb_q  [K-1][IMG_W];
    logic [PIXEL_W-1:0] win_q [K][K];
    logic [PIXEL_W-1:0] col_new_s [K];
    logic [WIN_N*PIXEL_W-1:0] win_flat_s;

    // Position of the pixel being accepted, its successor, and window validity.
    always_comb begin
        if (sof) begin
            cur_col_s = '0;
            cur_row_s = '0;
        end else begin
            cur_col_s = col_q;
            cur_row_s = row_q;
        end
        if (cur_col_s == CW'(IMG_W - 1)) begin
            col_d = '0;
            if (cur_row_s == RW'(IMG_H - 1)) begin
                row_d = '0;
            end else begin
                row_d = cur_row_s + RW'(1);
            end
        end else begin
            col_d = cur_col_s + CW'(1);
            row_d = cur_row_s;
        end
        // Only windows lying entirely inside the image (no row/col wrap).
        win_ok_s = (cur_row_s >= RW'(K - 1)) && (cur_col_s >= CW'(K - 1));
    end

    // Row/column position counters.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            col_q <= '0;
            row_q <= '0;
        end else if (pixel_valid) begin
            col_q <= col_d;
            row_q <= row_d;
        end else begin
            col_q <= col_q;
            row_q <= row_q;
        end
    end

    // Incoming column: row K-1 is the new pixel, older rows come out of the
    // line buffers (buffer j delays by j+1 image rows).
    always_comb begin
        for (int r = 0; r < K; r++) begin
            col_new_s[r] = '0;
        end
        col_new_s[K-1] = pixel_in;
        for (int r = 0; r < K - 1; r++) begin
            col_new_s[r] = lb_q[K-2-r][IMG_W-1];
        end
    end

    // Line buffers and window shift together on every accepted pixel.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int j = 0; j < K - 1; j++) begin
                for (int x = 0; x < IMG_W; x++) begin
                    lb_q[j][x] <= '0;
                end
            end
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K; c++) begin
                    win_q[r][c] <= '0;
                end
            end
        end else if (pixel_valid) begin
            for (int j = 0; j < K - 1; j++) begin
                for (int x = IMG_W - 1; x > 0; x--) begin
                    lb_q[j][x] <= lb_q[j][x-1];
                end
                lb_q[j][0] <= (j == 0) ? pixel_in : lb_q[(j == 0) ? 0 : j - 1][IMG_W-1];
            end
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K - 1; c++) begin
                    win_q[r][c] <= win_q[r][c+1];
                end
                win_q[r][K-1] <= col_new_s[r];
            end
        end else begin
            win_q <= win_q;
            lb_q  <= lb_q;
        end
    end

    // Validity of the window now sitting in win_q; bubbles enter as zero.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            win_valid_q <= 1'b0;
        end else begin
            win_valid_q <= pixel_valid & win_ok_s;
        end
    end

    // Flatten the window into tree element order i = r*K + c.
    always_comb begin
        win_flat_s = '0;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                win_flat_s[(r*K+c)*PIXEL_W +: PIXEL_W] = win_q[r][c];
            end
        end
    end

    // All trees run in lockstep, so tree 0's valid speaks for every kernel.
    for (genvar n = 0; n < NUM_KERNELS; n++) begin : g_tree
        if (n == 0) begin : g_lead
            mult_adder_tree #(
                .N(WIN_N), .PIXEL_W(PIXEL_W), .WEIGHT_W(WEIGHT_W), .ACC_W(ACC_W)
            ) u_tree (
                .clock       (clock),
                .reset       (reset),
                .in_valid_i  (win_valid_q),
                .pixels_i    (win_flat_s),
                .weights_i   (kernel[n*WIN_N*WEIGHT_W +: WIN_N*WEIGHT_W]),
                .out_valid_o (out_valid),
                .sum_o       (pixel_out[n*ACC_W +: ACC_W])
            );
        end else begin : g_follow
            mult_adder_tree #(
                .N(WIN_N), .PIXEL_W(PIXEL_W), .WEIGHT_W(WEIGHT_W), .ACC_W(ACC_W)
            ) u_tree (
                .clock       (clock),
                .reset       (reset),
                .in_valid_i  (win_valid_q),
                .pixels_i    (win_flat_s),
                .weights_i   (kernel[n*WIN_N*WEIGHT_W +: WIN_N*WEIGHT_W]),
                .out_valid_o (),
                .sum_o       (pixel_out[n*ACC_W +: ACC_W])
            );
        end
    end

endmodule

// File: tb/tb_conv2d_stream.sv
// Bench for conv2d_stream (K=3, 4x4 image, two kernels). A behavioural model
// keeps the image as a 2D array indexed by position and computes each window
// sum directly; expected results are queued with their due cycle and compared
// every cycle. Directed ramps are additionally pinned to literal values.
module tb_conv2d_stream;

    localparam int PW  = 8;
    localparam int WW  = 8;
    localparam int AW  = 32;
    localparam int K   = 3;
    localparam int W   = 4;
    localparam int H   = 4;
    localparam int NK  = 2;
    localparam int LAT = 5;

    logic                   clock = 1'b0;
    logic                   reset = 1'b0;
    logic [PW-1:0]          pixel_in = '0;
    logic                   pixel_valid = 1'b0;
    logic                   sof = 1'b0;
    logic [NK*K*K*WW-1:0]   kernel = '0;
    logic [NK*AW-1:0]       pixel_out;
    logic                   out_valid;

    conv2d_stream #(
        .PIXEL_W(PW), .WEIGHT_W(WW), .ACC_W(AW), .K(K),
        .IMG_W(W), .IMG_H(H), .NUM_KERNELS(NK)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .pixel_in    (pixel_in),
        .pixel_valid (pixel_valid),
        .sof         (sof),
        .kernel      (kernel),
        .pixel_out   (pixel_out),
        .out_valid   (out_valid)
    );

    always #5 clock = ~clock;

    typedef struct {
        int due;
        int v0;
        int v1;
    } exp_t;

    exp_t        expq[$];
    int          log0[$];
    int          log1[$];
    int          total = 0;
    int          bad = 0;
    int          edge_cnt = 0;
    int          mr = 0;
    int          mc = 0;
    int          img[H][W];
    logic [31:0] last0 = 32'd0;
    logic [31:0] last1 = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h) at edge %0d",
                     name, $signed(act), act, $signed(exp), exp, edge_cnt);
        end
    endtask

    function automatic int wt(input int n, input int i);
        logic [WW-1:0] b;
        b = kernel[(n*K*K+i)*WW +: WW];
        return int'($signed(b));
    endfunction

    // Model: place the pixel in the image and, if a full window ends here,
    // compute every kernel's sum and queue it LAT edges past the accept edge.
    task automatic model_accept(input bit s, input logic [PW-1:0] p);
        exp_t e;
        int   acc [NK];
        if (s) begin
            mr = 0;
            mc = 0;
        end
        img[mr][mc] = int'(p);
        if (mr >= K - 1 && mc >= K - 1) begin
            for (int n = 0; n < NK; n++) begin
                acc[n] = 0;
                for (int r = 0; r < K; r++) begin
                    for (int c = 0; c < K; c++) begin
                        acc[n] += img[mr-K+1+r][mc-K+1+c] * wt(n, r*K+c);
                    end
                end
`ifdef CONV2D_STREAM_RELU_EN
                if (acc[n] < 0) acc[n] = 0;
`endif
            end
            e.due = edge_cnt + 1 + LAT;
            e.v0  = acc[0];
            e.v1  = acc[1];
            expq.push_back(e);
        end
        mc++;
        if (mc == W) begin
            mc = 0;
            mr++;
            if (mr == H) mr = 0;
        end
    endtask

    task automatic compare();
        bit ev;
        ev = (expq.size() > 0) && (expq[0].due == edge_cnt);
        chk("out_valid", 32'(out_valid), 32'(ev));
        if (out_valid) begin
            log0.push_back(int'(pixel_out[31:0]));
            log1.push_back(int'(pixel_out[63:32]));
        end
        if (ev) begin
            chk("k0_result", pixel_out[31:0], 32'(expq[0].v0));
            chk("k1_result", pixel_out[63:32], 32'(expq[0].v1));
            last0 = 32'(expq[0].v0);
            last1 = 32'(expq[0].v1);
            void'(expq.pop_front());
        end else begin
            chk("k0_hold", pixel_out[31:0], last0);
            chk("k1_hold", pixel_out[63:32], last1);
        end
    endtask

    // One clock: check outputs at the falling edge, then drive the next input.
    task automatic step(input bit v, input bit s, input logic [PW-1:0] p);
        @(negedge clock);
        edge_cnt++;
        compare();
        pixel_valid = v;
        sof         = s & v;
        pixel_in    = p;
        if (v && reset) model_accept(s, p);
    endtask

    task automatic drain();
        repeat (LAT + 3) step(1'b0, 1'b0, 8'd0);
    endtask

    task automatic ramp(input bit with_sof, input bit bubbles);
        for (int i = 0; i < W * H; i++) begin
            if (bubbles && i > 0) step(1'b0, 1'b0, 8'($urandom));
            step(1'b1, with_sof && (i == 0), 8'(i));
        end
    endtask

    task automatic set_kernels(input int w0, input int w1);
        for (int i = 0; i < K * K; i++) begin
            kernel[i*WW +: WW]         = 8'(w0);
            kernel[(K*K+i)*WW +: WW]   = 8'(w1);
        end
    endtask

    // Hand-computed 4x4 ramp window sums: centres 5, 6, 9, 10 times nine.
    task automatic check_log(input int frames, input int m1);
        int base [4];
        int e1;
        base = '{45, 54, 81, 90};
        chk("pulse_count", 32'(log0.size()), 32'(4 * frames));
        for (int i = 0; i < 4 * frames && i < log0.size(); i++) begin
            e1 = base[i % 4] * m1;
`ifdef CONV2D_STREAM_RELU_EN
            if (e1 < 0) e1 = 0;
`endif
            chk("lit_k0", 32'(log0[i]), 32'(base[i % 4]));
            chk("lit_k1", 32'(log1[i]), 32'(e1));
        end
        log0.delete();
        log1.delete();
    endtask

    task automatic reset_mid();
        #2 reset = 1'b0;
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_k0", pixel_out[31:0], 32'd0);
        chk("rst_k1", pixel_out[63:32], 32'd0);
        expq.delete();
        mr = 0;
        mc = 0;
        last0 = 32'd0;
        last1 = 32'd0;
        step(1'b0, 1'b0, 8'd0);
        step(1'b0, 1'b0, 8'd0);
        reset = 1'b1;
        log0.delete();
        log1.delete();
    endtask

    initial begin
        logic [31:0] exp_neg;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                img[r][c] = 0;
            end
        end

        // Reset state
        step(1'b0, 1'b0, 8'd0);
        chk("reset_valid", 32'(out_valid), 32'd0);
        chk("reset_k0", pixel_out[31:0], 32'd0);
        chk("reset_k1", pixel_out[63:32], 32'd0);
        step(1'b0, 1'b0, 8'd0);
        reset = 1'b1;

        // Basic ramp
        set_kernels(1, 2);
        ramp(1'b1, 1'b0);
        drain();
        check_log(1, 2);

        // Bubbles every other cycle
        ramp(1'b1, 1'b1);
        drain();
        check_log(1, 2);

        // Signed weights on kernel 1
        set_kernels(1, -1);
        ramp(1'b1, 1'b0);
        drain();
`ifdef CONV2D_STREAM_RELU_EN
        exp_neg = 32'h0000_0000;
`else
        exp_neg = 32'hFFFF_FFD3;
`endif
        chk("neg45_hex", (log1.size() > 0) ? 32'(log1[0]) : 32'hDEAD_BEEF, exp_neg);
        check_log(1, -1);

        // Frame restart after a partial frame
        set_kernels(1, 2);
        for (int i = 0; i < 7; i++) step(1'b1, i == 0, 8'(i));
        ramp(1'b1, 1'b0);
        drain();
        check_log(1, 2);

        // Back-to-back frames, no sof on the second
        ramp(1'b1, 1'b0);
        ramp(1'b0, 1'b0);
        drain();
        check_log(2, 2);

        // Reset with windows in flight, then a clean ramp
        for (int i = 0; i < 12; i++) step(1'b1, i == 0, 8'(i));
        reset_mid();
        ramp(1'b1, 1'b0);
        drain();
        check_log(1, 2);

        // Randomized streams with random weights, gaps and occasional sof
        for (int t = 0; t < 5; t++) begin
            for (int i = 0; i < NK * K * K; i++) kernel[i*WW +: WW] = 8'($urandom);
            for (int j = 0; j < 70; j++) begin
                step($urandom_range(3, 0) != 0, $urandom_range(39, 0) == 0, 8'($urandom));
            end
            drain();
        end

        chk("queue_empty", 32'(expq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
